// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips and normalises two corners, then rasters the
// rectangle into the VGA pixel port with four colour patterns and backpressure.
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] colour,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic          plot_ready,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FILL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] base_q, base_d;
  logic [XW-1:0] xlo_q, xlo_d;
  logic [XW-1:0] xhi_q, xhi_d;
  logic [YW-1:0] ylo_q, ylo_d;
  logic [YW-1:0] yhi_q, yhi_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [XW-1:0] xl, xh;
  logic [YW-1:0] yl, yh;

  function automatic logic [CW-1:0] pix(
    input logic [1:0]    m,
    input logic [CW-1:0] c,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    logic [CW-1:0] r;
    unique case (m)
      2'd0:    r = c;
      2'd1:    r = x[CW-1:0];
      2'd2:    r = y[CW-1:0];
      default: r = (x[0] ^ y[0]) ? ~c : c;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    xlo_d   = xlo_q;
    xhi_d   = xhi_q;
    ylo_d   = ylo_q;
    yhi_d   = yhi_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = plot_q;
    busy_d  = busy_q;
    done_d  = done_q;
    xl      = xlo_q;
    xh      = xhi_q;
    yl      = ylo_q;
    yh      = yhi_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = colour;
          xlo_d   = x0;
          xhi_d   = x1;
          ylo_d   = y0;
          yhi_d   = y1;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        // Normalise the corners, then clamp the far edge to the screen.
        if (xlo_q > xhi_q) begin
          xl = xhi_q;
          xh = xlo_q;
        end
        if (ylo_q > yhi_q) begin
          yl = yhi_q;
          yh = ylo_q;
        end
        if (int'(xh) > SCREEN_W - 1) xh = X_LAST;
        if (int'(yh) > SCREEN_H - 1) yh = Y_LAST;
        xlo_d = xl;
        xhi_d = xh;
        ylo_d = yl;
        yhi_d = yh;
        if (int'(xl) >= SCREEN_W || int'(yl) >= SCREEN_H) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          x_d     = xl;
          y_d     = yl;
          col_d   = pix(mode_q, base_q, xl, yl);
          plot_d  = 1'b1;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (plot_q && plot_ready) begin
          if (x_q == xhi_q) begin
            if (y_q == yhi_q) begin
              plot_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              x_d = xlo_q;
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
          col_d = pix(mode_q, base_q, x_d, y_d);
        end
      end

      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      base_q  <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      ylo_q   <= '0;
      yhi_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      xlo_q   <= xlo_d;
      xhi_q   <= xhi_d;
      ylo_q   <= ylo_d;
      yhi_q   <= yhi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign vga_plot   = plot_q;

endmodule
